program_loader: RTL and testbench

- Write-side counterpart to the picoMIPS instruction fetch path. The fetch path only reads program memory; this block writes instructions into it at run time from the board switches and a push-key, with no resynthesis.
- Assembles each I_SIZE-bit instruction from two switch chunks and issues a single-cycle write strobe to the program RAM.
- Holds the CPU (PC hold/reset) for the whole load session and reports progress for the demo display.

---
 rtl/program_loader_if.sv | 27 ++
 rtl/program_loader.sv | 118 +++++++++++
 tb/tb_program_loader.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_if.sv
// Board-side and program-RAM-side signals of the run-time program loader.
// master: the loader itself. slave: the board/RAM side.
interface program_loader_if #(
  parameter int P_SIZE = 5,
  parameter int I_SIZE = 17
);
  logic [9:0]        switchesIn;
  logic              keyIn;
  logic              loadReq;
  logic              memWrite;
  logic [P_SIZE-1:0] memAddr;
  logic [I_SIZE-1:0] memData;
  logic              cpuHold;
  logic              loadDone;
  logic [P_SIZE-1:0] displayAddr;
  logic [2:0]        displayState;

  modport master (
    input  switchesIn, keyIn, loadReq,
    output memWrite, memAddr, memData, cpuHold, loadDone, displayAddr, displayState
  );

  modport slave (
    output switchesIn, keyIn, loadReq,
    input  memWrite, memAddr, memData, cpuHold, loadDone, displayAddr, displayState
  );
endinterface

// File: rtl/program_loader.sv
// Writes instructions into picoMIPS program RAM from two switch chunks per
// key press, holding the CPU for the duration of the load session.
//
// state | meaning
// IDLE  | CPU running, waiting for a load request
// LOW   | waiting for key press carrying instruction bits [8:0]
// HIGH  | waiting for key press carrying upper bits and end-of-program flag
// WRITE | one-cycle RAM write strobe
// DONE  | one-cycle session-complete pulse, then release the CPU
module program_loader #(
  parameter int N      = 8,
  parameter int O_SIZE = 6,
  parameter int R_SIZE = 3,
  parameter int P_SIZE = 5,
  parameter int I_SIZE = O_SIZE + R_SIZE + N
) (
  input logic               clk,
  input logic               reset,
  program_loader_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOW   = 3'd1,
    S_HIGH  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state, state_next;
  logic [2:0]        key_sync, req_sync;
  logic              key_edge, req_edge;
  logic [8:0]        low_chunk;
  logic              eop;
  logic [P_SIZE-1:0] mem_addr;
  logic [I_SIZE-1:0] mem_data;
  logic              last_write;

  // Two synchroniser flops followed by one edge-detect flop per raw input.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_sync <= '0;
      req_sync <= '0;
    end else begin
      key_sync <= {key_sync[1:0], bus.keyIn};
      req_sync <= {req_sync[1:0], bus.loadReq};
    end
  end

  assign key_edge   = key_sync[1] & ~key_sync[2];
  assign req_edge   = req_sync[1] & ~req_sync[2];
  assign last_write = eop | (&mem_addr);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (req_edge) state_next = S_LOW;
      S_LOW: begin
        if (req_edge)      state_next = S_LOW;
        else if (key_edge) state_next = S_HIGH;
      end
      S_HIGH: begin
        if (req_edge)      state_next = S_LOW;
        else if (key_edge) state_next = S_WRITE;
      end
      S_WRITE: state_next = last_write ? S_DONE : S_LOW;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // A request edge outranks a key edge in the same cycle, aborting any partial entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_addr  <= '0;
      mem_data  <= '0;
      low_chunk <= '0;
      eop       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (req_edge) mem_addr <= '0;
        S_LOW: begin
          if (req_edge)      mem_addr  <= '0;
          else if (key_edge) low_chunk <= bus.switchesIn[8:0];
        end
        S_HIGH: begin
          if (req_edge) begin
            mem_addr <= '0;
          end else if (key_edge) begin
            eop      <= bus.switchesIn[9];
            mem_data <= {bus.switchesIn[I_SIZE-10:0], low_chunk};
          end
        end
        S_WRITE: if (!last_write) mem_addr <= mem_addr + P_SIZE'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.memWrite     = 1'b0;
    bus.loadDone     = 1'b0;
    bus.cpuHold      = 1'b0;
    bus.memAddr      = mem_addr;
    bus.memData      = mem_data;
    bus.displayAddr  = mem_addr;
    bus.displayState = state;
    if (state == S_WRITE) bus.memWrite = 1'b1;
    if (state == S_DONE)  bus.loadDone = 1'b1;
    if (state != S_IDLE)  bus.cpuHold  = 1'b1;
  end

endmodule

// File: tb/tb_program_loader.sv
// Randomised bench for program_loader: expected RAM writes come from a
// queue-based model of load sessions (address counter, eop, last-address stop).
module tb_program_loader;
  localparam int P = 5;
  localparam int I = 17;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  program_loader_if #(.P_SIZE(P), .I_SIZE(I)) bus ();

  program_loader #(.P_SIZE(P), .I_SIZE(I)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int done_cnt    = 0;
  int model_addr  = 0;
  logic [P+I-1:0] obs_q[$];
  logic [P+I-1:0] exp_q[$];
  logic prev_write = 1'b0;

  // Records every write strobe and checks strobe width / DONE placement.
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      if (bus.memWrite) begin
        obs_q.push_back({bus.memAddr, bus.memData});
        vectors++;
        if (prev_write) begin
          miscompares++;
          $display("FAIL strobe_width: memWrite high in consecutive cycles, required single-cycle");
        end
      end
      if (bus.loadDone) begin
        done_cnt++;
        vectors++;
        if (prev_write !== 1'b1 || bus.cpuHold !== 1'b1) begin
          miscompares++;
          $display("FAIL done_timing: prev memWrite=%b cpuHold=%b, required 1 1", prev_write, bus.cpuHold);
        end
      end
      prev_write = bus.memWrite;
    end else begin
      prev_write = 1'b0;
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_session();
    @(posedge clk); #1 bus.loadReq = 1'b1;
    wait_cycles(4);
    bus.loadReq = 1'b0;
    wait_cycles(4);
    model_addr = 0;
  endtask

  task automatic press_key(input logic [9:0] sw);
    @(posedge clk); #1 bus.switchesIn = sw; bus.keyIn = 1'b1;
    wait_cycles(4);
    bus.keyIn = 1'b0;
    wait_cycles(4);
  endtask

  task automatic model_word(input logic [8:0] lo, input logic [7:0] hi, input logic e, output logic fin);
    logic [P-1:0] a;
    a = model_addr[P-1:0];
    exp_q.push_back({a, hi, lo});
    fin = e || (model_addr == (1 << P) - 1);
    if (!fin) model_addr++;
  endtask

  task automatic load_word(input logic [8:0] lo, input logic [7:0] hi, input logic e, output logic fin);
    logic junk;
    junk = 1'($urandom);
    press_key({1'b0, lo});
    press_key({e, junk, hi});
    model_word(lo, hi, e, fin);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    wait_cycles(2);
    vectors++;
    if ({bus.memWrite, bus.memAddr, bus.memData, bus.cpuHold, bus.loadDone, bus.displayState} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: wr=%b addr=%h data=%h hold=%b done=%b st=%0d, required all 0",
               bus.memWrite, bus.memAddr, bus.memData, bus.cpuHold, bus.loadDone, bus.displayState);
    end
    reset = 1'b0;
    obs_q.delete(); exp_q.delete();
    for (int i = 0; i < 3; i++) press_key(10'($urandom));
    vectors++;
    if (obs_q.size() !== 0 || bus.cpuHold !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_keys: writes=%0d hold=%b, required 0 0", obs_q.size(), bus.cpuHold);
    end
  endtask

  task automatic test_single();
    logic fin;
    int d0;
    obs_q.delete(); exp_q.delete();
    d0 = done_cnt;
    start_session();
    vectors++;
    if (bus.cpuHold !== 1'b1 || bus.displayState !== 3'd1) begin
      miscompares++;
      $display("FAIL single_start: hold=%b st=%0d, required 1 1", bus.cpuHold, bus.displayState);
    end
    press_key(10'h1A5);
    vectors++;
    if (bus.displayState !== 3'd2) begin
      miscompares++;
      $display("FAIL single_low: st=%0d, required 2", bus.displayState);
    end
    press_key(10'h2B3);
    model_word(9'h1A5, 8'hB3, 1'b1, fin);
    vectors++;
    if (obs_q.size() !== 1 || obs_q[0] !== {5'd0, 17'h167A5}) begin
      miscompares++;
      $display("FAIL single_write: count=%0d first=%h, required 1 %h", obs_q.size(),
               (obs_q.size() > 0) ? obs_q[0] : '0, {5'd0, 17'h167A5});
    end
    vectors++;
    if (done_cnt - d0 !== 1 || bus.cpuHold !== 1'b0 || bus.displayState !== 3'd0 || bus.displayAddr !== 5'd0) begin
      miscompares++;
      $display("FAIL single_end: dones=%0d hold=%b st=%0d daddr=%0d, required 1 0 0 0",
               done_cnt - d0, bus.cpuHold, bus.displayState, bus.displayAddr);
    end
  endtask

  task automatic test_multi();
    logic fin;
    int d0;
    obs_q.delete(); exp_q.delete();
    d0 = done_cnt;
    start_session();
    for (int w = 0; w < 3; w++) begin
      load_word(9'($urandom), 8'($urandom), w == 2, fin);
      if (w < 2) begin
        vectors++;
        if (bus.cpuHold !== 1'b1 || bus.displayState !== 3'd1) begin
          miscompares++;
          $display("FAIL multi_hold w%0d: hold=%b st=%0d, required 1 1", w, bus.cpuHold, bus.displayState);
        end
      end
    end
    vectors++;
    if (obs_q.size() !== exp_q.size()) begin
      miscompares++;
      $display("FAIL multi_count: got %0d writes, required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL multi_write %0d: got %h, required %h", i, obs_q[i], exp_q[i]);
      end
    end
    vectors++;
    if (bus.displayAddr !== 5'd2 || done_cnt - d0 !== 1 || bus.cpuHold !== 1'b0) begin
      miscompares++;
      $display("FAIL multi_end: daddr=%0d dones=%0d hold=%b, required 2 1 0",
               bus.displayAddr, done_cnt - d0, bus.cpuHold);
    end
  endtask

  task automatic test_full();
    logic fin;
    int d0;
    obs_q.delete(); exp_q.delete();
    d0 = done_cnt;
    start_session();
    for (int w = 0; w < (1 << P); w++) load_word(9'($urandom), 8'($urandom), 1'b0, fin);
    press_key(10'($urandom));
    press_key(10'($urandom));
    vectors++;
    if (obs_q.size() !== (1 << P)) begin
      miscompares++;
      $display("FAIL full_count: got %0d writes, required %0d", obs_q.size(), 1 << P);
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL full_write %0d: got %h, required %h", i, obs_q[i], exp_q[i]);
      end
    end
    vectors++;
    if (done_cnt - d0 !== 1 || bus.displayAddr !== 5'd31 || bus.displayState !== 3'd0) begin
      miscompares++;
      $display("FAIL full_end: dones=%0d daddr=%0d st=%0d, required 1 31 0",
               done_cnt - d0, bus.displayAddr, bus.displayState);
    end
  endtask

  task automatic test_abort();
    logic fin;
    obs_q.delete(); exp_q.delete();
    start_session();
    load_word(9'($urandom), 8'($urandom), 1'b0, fin);
    press_key({1'b0, 9'($urandom)});
    start_session();
    vectors++;
    if (bus.displayState !== 3'd1 || bus.displayAddr !== 5'd0 || bus.cpuHold !== 1'b1 || obs_q.size() !== 1) begin
      miscompares++;
      $display("FAIL abort_state: st=%0d daddr=%0d hold=%b writes=%0d, required 1 0 1 1",
               bus.displayState, bus.displayAddr, bus.cpuHold, obs_q.size());
    end
    load_word(9'($urandom), 8'($urandom), 1'b1, fin);
    vectors++;
    if (obs_q.size() !== exp_q.size()) begin
      miscompares++;
      $display("FAIL abort_count: got %0d writes, required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL abort_write %0d: got %h, required %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_sync();
    logic fin;
    logic [8:0] lo;
    logic [7:0] hi;
    obs_q.delete(); exp_q.delete();
    start_session();
    lo = 9'($urandom);
    @(posedge clk); #1 bus.switchesIn = {1'b0, lo}; bus.keyIn = 1'b1;
    wait_cycles(50);
    bus.keyIn = 1'b0;
    wait_cycles(4);
    vectors++;
    if (bus.displayState !== 3'd2) begin
      miscompares++;
      $display("FAIL held_key: st=%0d, required 2", bus.displayState);
    end
    hi = 8'($urandom);
    press_key({1'b1, 1'b0, hi});
    model_word(lo, hi, 1'b1, fin);

    start_session();
    press_key({1'b0, 9'($urandom)});
    @(posedge clk); #1 bus.switchesIn = 10'($urandom); bus.keyIn = 1'b1; bus.loadReq = 1'b1;
    wait_cycles(4);
    bus.keyIn = 1'b0; bus.loadReq = 1'b0;
    wait_cycles(4);
    model_addr = 0;
    vectors++;
    if (bus.displayState !== 3'd1 || obs_q.size() !== 1) begin
      miscompares++;
      $display("FAIL coincident: st=%0d writes=%0d, required 1 1", bus.displayState, obs_q.size());
    end
    load_word(9'($urandom), 8'($urandom), 1'b1, fin);

    start_session();
    press_key({1'b0, 9'($urandom)});
    @(posedge clk); #1 reset = 1'b1;
    wait_cycles(2);
    vectors++;
    if (bus.displayState !== 3'd0 || bus.cpuHold !== 1'b0 || bus.memWrite !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_high: st=%0d hold=%b wr=%b, required 0 0 0",
               bus.displayState, bus.cpuHold, bus.memWrite);
    end
    reset = 1'b0;
    wait_cycles(6);
    vectors++;
    if (obs_q.size() !== exp_q.size()) begin
      miscompares++;
      $display("FAIL sync_count: got %0d writes, required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL sync_write %0d: got %h, required %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    reset          = 1'b1;
    bus.switchesIn = '0;
    bus.keyIn      = 1'b0;
    bus.loadReq    = 1'b0;
    test_reset();
    test_single();
    test_multi();
    test_full();
    test_abort();
    test_sync();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
